sigma_delta_dac: RTL and testbench

Output stage placed directly downstream of the `dds` block: it takes the 8-bit sample stream on `dds.out` and applies runtime gain and offset with saturation. It then drives a first-order sigma-delta modulator that produces a single 1-bit pin, so the board needs only an RC low-pass instead of an 8-pin R-2R ladder. Gain and offset are loaded by the `communication` block using the same `set`-strobe style as the DDS tuning word. New values take effect only at a sample boundary, so the output never glitches.

---
 rtl/sigma_delta_dac_pkg.sv | 39 +++
 rtl/sigma_delta_dac_if.sv | 28 ++
 rtl/sigma_delta_dac_mod1.sv | 35 +++
 rtl/sigma_delta_dac.sv | 115 +++++++++++
 tb/tb_sigma_delta_dac.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/sigma_delta_dac_pkg.sv
// Shared constants, types and saturation helper for the sigma-delta output stage.
package dac_pkg;

    localparam int unsigned SAMPLE_W = 8;
    localparam int unsigned GAIN_W   = 8;
    localparam int unsigned OFFSET_W = 9;
    localparam int unsigned ACC_W    = 9;
    localparam int unsigned SUM_W    = 10;
    localparam int unsigned PROD_W   = 16;

    typedef logic        [SAMPLE_W-1:0] sample_t;
    typedef logic        [GAIN_W-1:0]   gain_t;
    typedef logic signed [OFFSET_W-1:0] offset_t;

    localparam gain_t   GAIN_RST   = 8'hFF;
    localparam offset_t OFFSET_RST = '0;

    // Saturated level plus the flag saying whether clamping occurred.
    typedef struct packed {
        logic    clip;
        sample_t level;
    } sat_t;

    // sum is 10-bit two's complement covering -256..510.
    function automatic sat_t saturate(input logic [SUM_W-1:0] sum);
        sat_t r;
        r.clip  = 1'b0;
        r.level = sum[SAMPLE_W-1:0];
        if (sum[SUM_W-1]) begin
            r.clip  = 1'b1;
            r.level = '0;
        end else if (sum[SUM_W-2]) begin
            r.clip  = 1'b1;
            r.level = '1;
        end
        return r;
    endfunction

endpackage

// File: rtl/sigma_delta_dac_if.sv
// Sample/control bus of the sigma-delta output stage.
//   master: drives en, sample, sample_valid, gain, offset, set, clr_clip
//   slave : drives dac_out, level, clip
interface sigma_delta_dac_if;
    import dac_pkg::*;

    logic    en;
    sample_t sample;
    logic    sample_valid;
    gain_t   gain;
    offset_t offset;
    logic    set;
    logic    clr_clip;
    logic    dac_out;
    sample_t level;
    logic    clip;

    modport master (
        output en, sample, sample_valid, gain, offset, set, clr_clip,
        input  dac_out, level, clip
    );

    modport slave (
        input  en, sample, sample_valid, gain, offset, set, clr_clip,
        output dac_out, level, clip
    );

endinterface

// File: rtl/sigma_delta_dac_mod1.sv
// First-order accumulator/carry sigma-delta modulator.
//   clk, rst_n : clock, async active-low reset
//   en         : low clears the accumulator and forces dac_out low
//   level      : input level L, giving L highs per 256 cycles
//   dac_out    : registered carry bitstream
module sd_mod1
    import dac_pkg::*;
(
    input  logic    clk,
    input  logic    rst_n,
    input  logic    en,
    input  sample_t level,
    output logic    dac_out
);

    logic [ACC_W-2:0] r_acc;
    logic [ACC_W-1:0] w_acc_next;

    assign w_acc_next = ACC_W'(r_acc) + ACC_W'(level);

    // Carry out of the 8-bit phase accumulator is the output bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc   <= '0;
            dac_out <= 1'b0;
        end else if (!en) begin
            r_acc   <= '0;
            dac_out <= 1'b0;
        end else begin
            r_acc   <= w_acc_next[ACC_W-2:0];
            dac_out <= w_acc_next[ACC_W-1];
        end
    end

endmodule

// File: rtl/sigma_delta_dac.sv
// Gain/offset/saturation pipeline feeding a 1-bit sigma-delta modulator.
//   clk, rst_n : 12 MHz clock, async active-low reset
//   bus        : slave side of sigma_delta_dac_if (sample stream, gain/offset
//                load strobe, clip clear; outputs dac_out, level, clip)
module sigma_delta_dac
    import dac_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    sigma_delta_dac_if.slave        bus
);

    gain_t       r_sh_gain;
    offset_t     r_sh_offset;
    gain_t       r_act_gain;
    offset_t     r_act_offset;
    sample_t     r_scaled;
    logic        r_s1_vld;
    sample_t     r_level;
    logic        r_clip;

    logic        w_accept;
    gain_t       w_gain_eff;
    offset_t     w_offset_eff;
    logic [PROD_W-1:0] w_prod;
    logic [SUM_W-1:0]  w_sum;
    sat_t        w_sat;
    logic        w_sat_hit;
    logic        w_dac_out;

    assign w_accept = bus.en & bus.sample_valid;

    // A set in the accepting cycle is forwarded straight into that sample.
    assign w_gain_eff   = bus.set ? bus.gain   : r_sh_gain;
    assign w_offset_eff = bus.set ? bus.offset : r_sh_offset;

    // sample*(gain+1) written as sample*gain + sample; max 65280 fits 16 bits.
    assign w_prod = PROD_W'(bus.sample) * PROD_W'(w_gain_eff) + PROD_W'(bus.sample);

    // Offset in the active register always belongs to the sample held in r_scaled.
    assign w_sum     = {2'b00, r_scaled} + {r_act_offset[OFFSET_W-1], r_act_offset};
    assign w_sat     = saturate(w_sum);
    assign w_sat_hit = w_accept & r_s1_vld & w_sat.clip;

    // Shadow registers load on every set, even while disabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sh_gain   <= GAIN_RST;
            r_sh_offset <= OFFSET_RST;
        end else if (bus.set) begin
            r_sh_gain   <= bus.gain;
            r_sh_offset <= bus.offset;
        end
    end

    // Active registers change only on a sample boundary.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_act_gain   <= GAIN_RST;
            r_act_offset <= OFFSET_RST;
        end else if (w_accept) begin
            r_act_gain   <= w_gain_eff;
            r_act_offset <= w_offset_eff;
        end
    end

    // Stage 1: scale; r_s1_vld marks that r_scaled holds a real sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_scaled <= '0;
            r_s1_vld <= 1'b0;
        end else if (!bus.en) begin
            r_scaled <= '0;
            r_s1_vld <= 1'b0;
        end else if (bus.sample_valid) begin
            r_scaled <= SAMPLE_W'(w_prod >> 8);
            r_s1_vld <= 1'b1;
        end
    end

    // Stage 2: offset and clamp; an empty stage 1 keeps level at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_level <= '0;
        end else if (!bus.en) begin
            r_level <= '0;
        end else if (bus.sample_valid) begin
            r_level <= r_s1_vld ? w_sat.level : '0;
        end
    end

    // Sticky clip: a saturation beats a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_clip <= 1'b0;
        end else if (w_sat_hit) begin
            r_clip <= 1'b1;
        end else if (bus.clr_clip) begin
            r_clip <= 1'b0;
        end
    end

    sd_mod1 u_mod (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (bus.en),
        .level   (r_level),
        .dac_out (w_dac_out)
    );

    assign bus.dac_out = w_dac_out;
    assign bus.level   = r_level;
    assign bus.clip    = r_clip;

endmodule

// File: tb/tb_sigma_delta_dac.sv
// Directed bench for sigma_delta_dac: gain, saturation, clip, boundary update,
// enable and asynchronous reset behaviour.
module tb_sigma_delta_dac;
    import dac_pkg::*;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    sigma_delta_dac_if bus ();

    sigma_delta_dac u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic count_highs(output int n);
        n = 0;
        repeat (256) begin
            tick();
            n += int'(bus.dac_out);
        end
    endtask

    // Load gain/offset with a one-cycle set strobe while streaming `smp`.
    task automatic load(input int g, input int o, input int smp);
        bus.gain   = gain_t'(g);
        bus.offset = offset_t'(o);
        bus.sample = sample_t'(smp);
        bus.set    = 1'b1;
        tick();
        bus.set    = 1'b0;
    endtask

    initial begin
        int  n;
        logic prev;
        logic alt_ok;
        n_checks = 0;
        n_fail   = 0;
        rst_n            = 1'b0;
        bus.en           = 1'b0;
        bus.sample       = '0;
        bus.sample_valid = 1'b0;
        bus.gain         = '0;
        bus.offset       = '0;
        bus.set          = 1'b0;
        bus.clr_clip     = 1'b0;
        #3;
        check("rst_dac", 32'(bus.dac_out), 0);
        check("rst_level", 32'(bus.level), 0);
        check("rst_clip", 32'(bus.clip), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Default unity gain: 128 -> level 128 after two edges, 1/0 alternation.
        bus.en = 1'b1;
        bus.sample_valid = 1'b1;
        bus.sample = 8'd128;
        tick();
        tick();
        check("default_level", 32'(bus.level), 128);
        n = 0;
        alt_ok = 1'b1;
        prev = 1'b1;
        repeat (256) begin
            tick();
            n += int'(bus.dac_out);
            if (bus.dac_out == prev) alt_ok = 1'b0;
            prev = bus.dac_out;
        end
        check("default_highs", 32'(n), 128);
        check("default_alternate", 32'(alt_ok), 1);

        // Gain 127: 200*128>>8 = 100.
        load(127, 0, 200);
        tick();
        check("gain127_level", 32'(bus.level), 100);
        count_highs(n);
        check("gain127_highs", 32'(n), 100);

        // Gain 0: 200*1>>8 = 0, output stays low.
        load(0, 0, 200);
        tick();
        check("gain0_level", 32'(bus.level), 0);
        count_highs(n);
        check("gain0_highs", 32'(n), 0);
        check("gain0_noclip", 32'(bus.clip), 0);

        // 200 + 100 saturates high.
        load(255, 100, 200);
        tick();
        check("sat_hi_level", 32'(bus.level), 255);
        check("sat_hi_clip", 32'(bus.clip), 1);

        // 20 - 50 saturates low.
        load(255, -50, 20);
        tick();
        check("sat_lo_level", 32'(bus.level), 0);

        // Clear clip with no saturation in flight.
        load(255, 0, 100);
        tick();
        check("nosat_level", 32'(bus.level), 100);
        check("clip_still_set", 32'(bus.clip), 1);
        bus.clr_clip = 1'b1;
        tick();
        bus.clr_clip = 1'b0;
        check("clr_clip", 32'(bus.clip), 0);

        // Clear coincident with a saturating stage-2 update: set wins.
        load(255, 200, 100);
        check("pre_coinc_clip", 32'(bus.clip), 0);
        bus.clr_clip = 1'b1;
        tick();
        bus.clr_clip = 1'b0;
        check("coinc_level", 32'(bus.level), 255);
        check("coinc_clip", 32'(bus.clip), 1);

        // Sample-boundary update: set while no sample is accepted.
        load(255, 0, 200);
        tick();
        check("pre_boundary_level", 32'(bus.level), 200);
        bus.sample_valid = 1'b0;
        load(63, 0, 200);
        check("boundary_hold0", 32'(bus.level), 200);
        tick();
        tick();
        check("boundary_hold1", 32'(bus.level), 200);
        bus.sample = 8'd255;
        bus.sample_valid = 1'b1;
        tick();
        check("boundary_hold2", 32'(bus.level), 200);
        tick();
        check("boundary_level", 32'(bus.level), 63);

        // Enable drop: 200*128>>8 + 10 = 110 before disabling.
        load(127, 10, 200);
        tick();
        check("pre_en_level", 32'(bus.level), 110);
        bus.en = 1'b0;
        tick();
        check("en0_dac", 32'(bus.dac_out), 0);
        check("en0_acc", 32'(u_dut.u_mod.r_acc), 0);
        check("en0_level", 32'(bus.level), 0);
        tick();
        check("en0_dac_hold", 32'(bus.dac_out), 0);
        check("en0_clip_kept", 32'(bus.clip), 1);

        // Re-enable without a new set: gain/offset retained.
        bus.en = 1'b1;
        tick();
        check("reen_dac_e1", 32'(bus.dac_out), 0);
        check("reen_level_e1", 32'(bus.level), 0);
        tick();
        check("reen_dac_e2", 32'(bus.dac_out), 0);
        check("reen_level_e2", 32'(bus.level), 110);
        count_highs(n);
        check("reen_highs", 32'(n), 110);

        // Asynchronous reset between edges.
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("arst_dac", 32'(bus.dac_out), 0);
        check("arst_level", 32'(bus.level), 0);
        check("arst_clip", 32'(bus.clip), 0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.sample = 8'd200;
        tick();
        tick();
        check("arst_gain_default", 32'(bus.level), 200);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
